// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared move codes, sequencer states and illegal-code check
package motor_pkg;

    localparam logic [2:0] MV_FWD     = 3'b000;
    localparam logic [2:0] MV_RIGHT   = 3'b001;
    localparam logic [2:0] MV_LEFT    = 3'b010;
    localparam logic [2:0] MV_STOP    = 3'b011;
    localparam logic [2:0] MV_TURN180 = 3'b100;
    localparam logic [2:0] MV_REV     = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    function automatic logic move_is_illegal(input logic [2:0] code);
        return code[2] & code[1];
    endfunction

endpackage

// File: rtl/motor_sequencer_if.sv
// rtl/motor_sequencer_if.sv - command handshake and wheel-decoder outputs of the motor sequencer
interface motor_sequencer_if #(
    parameter int DUR_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_move;
    logic [DUR_W-1:0] cmd_dur;
    logic             abort;
    logic [2:0]       move;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_move, cmd_dur, abort,
        input  cmd_ready, move, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_move, cmd_dur, abort,
        output cmd_ready, move, busy, done, err
    );
endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - TICK_DIV cycle divider with synchronous restart and one-cycle tick
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/motor_sequencer.sv
// rtl/motor_sequencer.sv - timed move-command scheduler; MOTOR_DEADTIME_EN enables stop dead-time
module motor_sequencer
    import motor_pkg::*;
#(
    parameter int TICK_DIV   = 100000,
    parameter int DUR_W      = 16,
    parameter int DEAD_TICKS = 20
) (
    input  logic             clk,
    input  logic             rst,
    motor_sequencer_if.slave bus
);
    localparam int DEAD_W = $clog2(DEAD_TICKS + 1);
    localparam int CNT_W  = (DUR_W > DEAD_W) ? DUR_W : DEAD_W;

    state_e           state_q, state_d;
    logic [2:0]       act_move_q, act_move_d;
    logic [2:0]       pend_move_q, pend_move_d;
    logic [2:0]       move_q, move_d;
    logic [DUR_W-1:0] act_dur_q, act_dur_d;
    logic [DUR_W-1:0] pend_dur_q, pend_dur_d;
    logic             pend_v_q, pend_v_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick, restart, accept, run_last, load, need_dead;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    assign bus.cmd_ready = !pend_v_q && !bus.abort && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

`ifdef MOTOR_DEADTIME_EN
    assign need_dead = (pend_move_q != act_move_q) && (act_move_q != MV_STOP);
`else
    assign need_dead = 1'b0;
`endif

    // Continuous commands (dur 0) end as soon as something is waiting in the slot.
    always_comb begin
        run_last = 1'b0;
        if (state_q == ST_RUN) begin
            if (act_dur_q == '0) begin
                run_last = pend_v_q;
            end else begin
                run_last = tick && (cnt_q == CNT_W'(act_dur_q) - 1'b1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        act_move_d  = act_move_q;
        act_dur_d   = act_dur_q;
        pend_v_d    = pend_v_q;
        pend_move_d = pend_move_q;
        pend_dur_d  = pend_dur_q;
        cnt_d       = cnt_q;
        move_d      = MV_STOP;
        restart     = 1'b0;
        load        = 1'b0;
        err_d       = accept && move_is_illegal(bus.cmd_move);

        if (accept) begin
            pend_v_d    = 1'b1;
            pend_move_d = move_is_illegal(bus.cmd_move) ? MV_STOP : bus.cmd_move;
            pend_dur_d  = bus.cmd_dur;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_v_q) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_last) begin
                    cnt_d = '0;
                    if (pend_v_q) begin
                        load    = 1'b1;
                        state_d = need_dead ? ST_DEAD : ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tick && (act_dur_q != '0)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DEAD: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(DEAD_TICKS - 1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        restart = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            act_move_d = pend_move_q;
            act_dur_d  = pend_dur_q;
            pend_v_d   = 1'b0;
            cnt_d      = '0;
            restart    = 1'b1;
        end

        if (bus.abort) begin
            state_d  = ST_IDLE;
            pend_v_d = 1'b0;
            cnt_d    = '0;
            restart  = 1'b1;
        end

        if (state_d == ST_RUN) begin
            move_d = act_move_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            act_move_q  <= MV_STOP;
            act_dur_q   <= '0;
            pend_v_q    <= 1'b0;
            pend_move_q <= MV_STOP;
            pend_dur_q  <= '0;
            move_q      <= MV_STOP;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            act_move_q  <= act_move_d;
            act_dur_q   <= act_dur_d;
            pend_v_q    <= pend_v_d;
            pend_move_q <= pend_move_d;
            pend_dur_q  <= pend_dur_d;
            move_q      <= move_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.move = move_q;
    assign bus.err  = err_q;
    assign bus.busy = (state_q != ST_IDLE) || pend_v_q;
    assign bus.done = run_last && !bus.abort;
endmodule

// File: tb/tb_motor_sequencer.sv
// tb/tb_motor_sequencer.sv - directed tables plus random traffic against a cycle-budget reference model
module tb_motor_sequencer;
    import motor_pkg::*;

    localparam int TICK_DIV   = 4;
    localparam int DEAD_TICKS = 2;
    localparam int DUR_W      = 8;
`ifdef MOTOR_DEADTIME_EN
    localparam bit DEAD_EN = 1'b1;
`else
    localparam bit DEAD_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0] code;
        logic [7:0] dur;
        logic [2:0] exp_move;
        int         exp_len;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [2:0] code;
        int         dur;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    motor_sequencer_if #(.DUR_W(DUR_W)) bus ();

    motor_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .DUR_W      (DUR_W),
        .DEAD_TICKS (DEAD_TICKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: remaining-cycle budgets for the running or stopping segment.
    cmd_t       m_pend[$];
    bit         m_run, m_dead, m_err;
    logic [2:0] m_act;
    int         m_act_dur, m_left, m_dead_left;

    logic [2:0] tr_move[$];
    logic       tr_done[$], tr_err[$], tr_ready[$], tr_busy[$];
    int         got_q[$], exp_q[$];
    vec_t       tbl[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_run = 1'b0; m_dead = 1'b0; m_err = 1'b0;
        m_act = MV_STOP; m_act_dur = 0; m_left = 0; m_dead_left = 0;
    endtask

    task automatic m_start(input cmd_t c);
        m_run     = 1'b1;
        m_dead    = 1'b0;
        m_act     = c.code;
        m_act_dur = c.dur;
        m_left    = (c.dur == 0) ? -1 : c.dur * TICK_DIV;
    endtask

    task automatic clear_traces();
        tr_move.delete(); tr_done.delete(); tr_err.delete(); tr_ready.delete(); tr_busy.delete();
    endtask

    task automatic cycle(input logic v, input logic [2:0] mv, input logic [7:0] d, input logic ab);
        logic       e_ready, e_busy, e_done, acc;
        logic [2:0] e_move;
        cmd_t       c;
        bus.cmd_valid = v;
        bus.cmd_move  = mv;
        bus.cmd_dur   = d;
        bus.abort     = ab;
        @(negedge clk);
        e_ready = (m_pend.size() == 0) && !ab;
        e_move  = m_run ? m_act : MV_STOP;
        e_busy  = m_run || m_dead || (m_pend.size() != 0);
        e_done  = m_run && !ab && ((m_left == 1) || ((m_left < 0) && (m_pend.size() != 0)));
        chk("cyc_ready", 32'(bus.cmd_ready), 32'(e_ready));
        chk("cyc_move",  32'(bus.move),      32'(e_move));
        chk("cyc_busy",  32'(bus.busy),      32'(e_busy));
        chk("cyc_done",  32'(bus.done),      32'(e_done));
        chk("cyc_err",   32'(bus.err),       32'(m_err));
        tr_move.push_back(bus.move);
        tr_done.push_back(bus.done);
        tr_err.push_back(bus.err);
        tr_ready.push_back(bus.cmd_ready);
        tr_busy.push_back(bus.busy);

        acc   = v && e_ready;
        m_err = acc && (mv >= 3'd6);
        if (ab) begin
            m_run  = 1'b0;
            m_dead = 1'b0;
            m_pend.delete();
        end else begin
            if (m_run) begin
                if (e_done) begin
                    if (m_pend.size() != 0) begin
                        c = m_pend.pop_front();
                        if (DEAD_EN && (c.code != m_act) && (m_act != MV_STOP)) begin
                            m_run       = 1'b0;
                            m_dead      = 1'b1;
                            m_dead_left = DEAD_TICKS * TICK_DIV;
                            m_act       = c.code;
                            m_act_dur   = c.dur;
                        end else begin
                            m_start(c);
                        end
                    end else begin
                        m_run = 1'b0;
                    end
                end else if (m_left > 0) begin
                    m_left--;
                end
            end else if (m_dead) begin
                m_dead_left--;
                if (m_dead_left == 0) begin
                    c.code = m_act;
                    c.dur  = m_act_dur;
                    m_start(c);
                end
            end else if (m_pend.size() != 0) begin
                m_start(m_pend.pop_front());
            end
            if (acc) begin
                c.code = (mv >= 3'd6) ? MV_STOP : mv;
                c.dur  = int'(d);
                m_pend.push_back(c);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 8'd0, 1'b0);
    endtask

    task automatic add(input int v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic load_got(input int sel);
        got_q.delete();
        for (int i = 0; i < tr_move.size(); i++) begin
            case (sel)
                0:       got_q.push_back(int'(tr_move[i]));
                1:       got_q.push_back(int'(tr_done[i]));
                default: got_q.push_back(int'(tr_err[i]));
            endcase
        end
    endtask

    task automatic cmp_trace(input string name, input int sel);
        int idx;
        int n;
        load_got(sel);
        idx = -1;
        n   = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (idx < 0 && (i >= got_q.size() || i >= exp_q.size() || got_q[i] != exp_q[i])) idx = i;
        end
        total++;
        if (idx >= 0) begin
            bad++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, idx,
                     (idx < got_q.size()) ? got_q[idx] : -1, (idx < exp_q.size()) ? exp_q[idx] : -1);
        end
        exp_q.delete();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_move  = 3'd0;
        bus.cmd_dur   = 8'd0;
        bus.abort     = 1'b0;
        model_reset();

        tbl[0] = '{MV_FWD,     8'd3,   MV_FWD,     12,   1'b0};
        tbl[1] = '{3'b111,     8'd1,   MV_STOP,    4,    1'b1};
        tbl[2] = '{3'b110,     8'd2,   MV_STOP,    8,    1'b1};
        tbl[3] = '{MV_REV,     8'd1,   MV_REV,     4,    1'b0};
        tbl[4] = '{MV_RIGHT,   8'd5,   MV_RIGHT,   20,   1'b0};
        tbl[5] = '{MV_STOP,    8'd2,   MV_STOP,    8,    1'b0};
        tbl[6] = '{MV_TURN180, 8'd255, MV_TURN180, 1020, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_move",  32'(bus.move),      32'(MV_STOP));
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        chk("rst_err",   32'(bus.err),       32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        clear_traces();
        idle(1);
        chk("rel_ready", 32'(tr_ready[0]), 32'd1);
        chk("rel_busy",  32'(tr_busy[0]),  32'd0);
        chk("rel_move",  32'(tr_move[0]),  32'(MV_STOP));

        for (int k = 0; k < 7; k++) begin
            clear_traces();
            cycle(1'b1, tbl[k].code, tbl[k].dur, 1'b0);
            idle(tbl[k].exp_len + 3);
            add(MV_STOP, 2); add(int'(tbl[k].exp_move), tbl[k].exp_len); add(MV_STOP, 2);
            cmp_trace($sformatf("tbl%0d_move", k), 0);
            add(0, tbl[k].exp_len + 1); add(1, 1); add(0, 2);
            cmp_trace($sformatf("tbl%0d_done", k), 1);
            add(0, 1); add(int'(tbl[k].exp_err), 1); add(0, tbl[k].exp_len + 2);
            cmp_trace($sformatf("tbl%0d_err", k), 2);
        end

        clear_traces();
        cycle(1'b1, MV_FWD, 8'd2, 1'b0);
        cycle(1'b1, MV_LEFT, 8'd1, 1'b0);
        cycle(1'b1, MV_LEFT, 8'd1, 1'b0);
        idle(DEAD_EN ? 21 : 13);
        add(MV_STOP, 2); add(MV_FWD, 8);
        if (DEAD_EN) add(MV_STOP, 8);
        add(MV_LEFT, 4); add(MV_STOP, 2);
        cmp_trace("fwd_left_move", 0);

        clear_traces();
        cycle(1'b1, MV_FWD, 8'd2, 1'b0);
        cycle(1'b1, MV_FWD, 8'd2, 1'b0);
        cycle(1'b1, MV_FWD, 8'd2, 1'b0);
        idle(17);
        add(MV_STOP, 2); add(MV_FWD, 16); add(MV_STOP, 2);
        cmp_trace("fwd_fwd_move", 0);
        add(0, 9); add(1, 1); add(0, 7); add(1, 1); add(0, 2);
        cmp_trace("fwd_fwd_done", 1);

        clear_traces();
        cycle(1'b1, MV_REV, 8'd0, 1'b0);
        idle(5);
        cycle(1'b1, MV_REV, 8'd3, 1'b0);
        idle(1);
        cycle(1'b1, MV_LEFT, 8'd1, 1'b0);
        idle(2);
        cycle(1'b1, MV_RIGHT, 8'd1, 1'b1);
        cycle(1'b1, MV_RIGHT, 8'd1, 1'b1);
        idle(8);
        add(MV_STOP, 2); add(MV_REV, 10); add(MV_STOP, 9);
        cmp_trace("abort_move", 0);
        add(0, 7); add(1, 1); add(0, 13);
        cmp_trace("abort_done", 1);
        chk("abort_ready0", 32'(tr_ready[11]), 32'd0);
        chk("abort_ready1", 32'(tr_ready[12]), 32'd0);
        chk("abort_ready2", 32'(tr_ready[13]), 32'd1);
        chk("abort_busy",   32'(tr_busy[13]),  32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic       v, ab;
            logic [2:0] mv;
            logic [7:0] d;
            v  = ($urandom_range(0, 3) == 0);
            mv = 3'($urandom_range(0, 7));
            d  = 8'($urandom_range(0, 4));
            ab = ($urandom_range(0, 79) == 0);
            cycle(v, mv, d, ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
